fxu_reservation_station: RTL and testbench

- Per-FXU reservation station directly downstream of the instruction buffer; one instance each behind fxu_0 and fxu_1 dispatch ports.
- Accepts at most one dispatched instruction per cycle, holds it until both operands are valid, snoops the writeback broadcast bus (CDB) to capture pending operands by ROB-index tag, then issues the oldest ready entry to the fixed-point ALU over a valid/ready handshake.
- Drives `full` back to the instruction buffer, which uses it as fxu_N_full.

---
 rtl/fxu_reservation_station_if.sv | 46 ++++
 rtl/fxu_reservation_station.sv | 125 ++++++++++++
 tb/tb_fxu_reservation_station.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fxu_reservation_station_if.sv
// rtl/fxu_reservation_station_if.sv - dispatch, CDB and issue signal bundle for the FXU reservation station
interface fxu_reservation_station_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [TAG_W-1:0]  in_rob_idx;
  logic [3:0]        in_opcode;
  logic [7:0]        in_imm;
  logic              in_a_valid;
  logic [DATA_W-1:0] in_a_value;
  logic [TAG_W-1:0]  in_a_owner;
  logic              in_b_valid;
  logic [DATA_W-1:0] in_b_value;
  logic [TAG_W-1:0]  in_b_owner;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              flush;
  logic              full;
  logic              issue_valid;
  logic              issue_ready;
  logic [TAG_W-1:0]  issue_rob_idx;
  logic [3:0]        issue_opcode;
  logic [7:0]        issue_imm;
  logic [DATA_W-1:0] issue_a_value;
  logic [DATA_W-1:0] issue_b_value;

  modport master (
    output in_valid, in_rob_idx, in_opcode, in_imm,
           in_a_valid, in_a_value, in_a_owner,
           in_b_valid, in_b_value, in_b_owner,
           cdb_valid, cdb_tag, cdb_value, flush, issue_ready,
    input  full, issue_valid, issue_rob_idx, issue_opcode, issue_imm,
           issue_a_value, issue_b_value
  );

  modport slave (
    input  in_valid, in_rob_idx, in_opcode, in_imm,
           in_a_valid, in_a_value, in_a_owner,
           in_b_valid, in_b_value, in_b_owner,
           cdb_valid, cdb_tag, cdb_value, flush, issue_ready,
    output full, issue_valid, issue_rob_idx, issue_opcode, issue_imm,
           issue_a_value, issue_b_value
  );
endinterface

// File: rtl/fxu_reservation_station.sv
// rtl/fxu_reservation_station.sv - age-ordered compacting reservation station with CDB wakeup and oldest-ready issue
module fxu_reservation_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 16
) (
  input logic                   clk,
  input logic                   reset,
  fxu_reservation_station_if.slave rs
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = $clog2(DEPTH);

  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  rob_idx;
    logic [3:0]        opcode;
    logic [7:0]        imm;
    logic              a_valid;
    logic [DATA_W-1:0] a_value;
    logic [TAG_W-1:0]  a_owner;
    logic              b_valid;
    logic [DATA_W-1:0] b_value;
    logic [TAG_W-1:0]  b_owner;
  } entry_t;

  entry_t           slot_q [DEPTH];
  entry_t           woke   [DEPTH];
  entry_t           slot_d [DEPTH];
  entry_t           new_entry;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] push_idx;
  logic [DEPTH-1:0] ready;
  logic [SEL_W-1:0] sel;
  logic             any_ready;
  logic             full;
  logic             push;
  logic             pop;

  // Captures a broadcast result into whichever operands of a live entry are waiting on that tag.
  function automatic entry_t wake(entry_t e, logic cv, logic [TAG_W-1:0] tag, logic [DATA_W-1:0] val);
    entry_t r;
    r = e;
    if (cv && e.busy && !e.a_valid && e.a_owner == tag) begin
      r.a_valid = 1'b1;
      r.a_value = val;
    end
    if (cv && e.busy && !e.b_valid && e.b_owner == tag) begin
      r.b_valid = 1'b1;
      r.b_value = val;
    end
    return r;
  endfunction

  assign full = (count_q == CNT_W'(DEPTH));

  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = slot_q[i].busy & slot_q[i].a_valid & slot_q[i].b_valid;
    end
  end

  always_comb begin
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) sel = SEL_W'(i);
    end
  end

  assign any_ready = |ready;
  assign push      = rs.in_valid & ~full & ~rs.flush;
  assign pop       = any_ready & rs.issue_ready & ~rs.flush;

  assign rs.full          = full;
  assign rs.issue_valid   = any_ready;
  assign rs.issue_rob_idx = any_ready ? slot_q[sel].rob_idx : '0;
  assign rs.issue_opcode  = any_ready ? slot_q[sel].opcode  : '0;
  assign rs.issue_imm     = any_ready ? slot_q[sel].imm     : '0;
  assign rs.issue_a_value = any_ready ? slot_q[sel].a_value : '0;
  assign rs.issue_b_value = any_ready ? slot_q[sel].b_value : '0;

  always_comb begin
    new_entry         = '0;
    new_entry.busy    = 1'b1;
    new_entry.rob_idx = rs.in_rob_idx;
    new_entry.opcode  = rs.in_opcode;
    new_entry.imm     = rs.in_imm;
    new_entry.a_valid = rs.in_a_valid;
    new_entry.a_value = rs.in_a_valid ? rs.in_a_value : '0;
    new_entry.a_owner = rs.in_a_owner;
    new_entry.b_valid = rs.in_b_valid;
    new_entry.b_value = rs.in_b_valid ? rs.in_b_value : '0;
    new_entry.b_owner = rs.in_b_owner;
    new_entry         = wake(new_entry, rs.cdb_valid, rs.cdb_tag, rs.cdb_value);

    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = wake(slot_q[i], rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
    end

    // Entries at and above the popped slot take their younger neighbour, wakeups included.
    for (int i = 0; i < DEPTH - 1; i++) begin
      slot_d[i] = (pop && SEL_W'(i) >= sel) ? woke[i + 1] : woke[i];
    end
    slot_d[DEPTH-1] = pop ? '0 : woke[DEPTH-1];

    push_idx = count_q - CNT_W'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      if (push && push_idx == CNT_W'(i)) slot_d[i] = new_entry;
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset || rs.flush) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end
endmodule

// File: tb/tb_fxu_reservation_station.sv
// tb/tb_fxu_reservation_station.sv - randomized and directed checks of fxu_reservation_station against a queue model
module tb_fxu_reservation_station;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fxu_reservation_station_if #(.TAG_W(4), .DATA_W(16)) bus ();

  fxu_reservation_station #(.DEPTH(DEPTH), .TAG_W(4), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (bus)
  );

  typedef struct {
    logic [3:0]  rob;
    logic [3:0]  op;
    logic [7:0]  imm;
    bit          av;
    logic [15:0] a;
    logic [3:0]  ao;
    bit          bv;
    logic [15:0] b;
    logic [3:0]  bo;
  } m_ent_t;

  m_ent_t q[$];
  int     n_pass  = 0;
  int     n_total = 0;
  bit     chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int oldest_ready();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].av && q[i].bv) return i;
    end
    return -1;
  endfunction

  function automatic logic [47:0] dut_payload();
    return {bus.issue_rob_idx, bus.issue_opcode, bus.issue_imm, bus.issue_a_value, bus.issue_b_value};
  endfunction

  task automatic tick();
    int          s;
    bit          was_full;
    m_ent_t      e;
    logic [47:0] exp_pl;
    @(negedge clk);
    s = oldest_ready();
    if (chk_en) begin
      exp_pl = '0;
      if (s >= 0) exp_pl = {q[s].rob, q[s].op, q[s].imm, q[s].a, q[s].b};
      check("full", 64'(bus.full), 64'(q.size() == DEPTH));
      check("issue_valid", 64'(bus.issue_valid), 64'(s >= 0));
      check("issue_payload", 64'(dut_payload()), 64'(exp_pl));
    end
    if (reset || bus.flush) begin
      q.delete();
    end else begin
      was_full = (q.size() == DEPTH);
      if (s >= 0 && bus.issue_ready) q.delete(s);
      for (int i = 0; i < q.size(); i++) begin
        if (bus.cdb_valid && !q[i].av && q[i].ao == bus.cdb_tag) begin q[i].av = 1; q[i].a = bus.cdb_value; end
        if (bus.cdb_valid && !q[i].bv && q[i].bo == bus.cdb_tag) begin q[i].bv = 1; q[i].b = bus.cdb_value; end
      end
      if (bus.in_valid && !was_full) begin
        e.rob = bus.in_rob_idx; e.op = bus.in_opcode; e.imm = bus.in_imm;
        e.av = bus.in_a_valid; e.a = bus.in_a_valid ? bus.in_a_value : 16'h0; e.ao = bus.in_a_owner;
        e.bv = bus.in_b_valid; e.b = bus.in_b_valid ? bus.in_b_value : 16'h0; e.bo = bus.in_b_owner;
        if (bus.cdb_valid && !e.av && e.ao == bus.cdb_tag) begin e.av = 1; e.a = bus.cdb_value; end
        if (bus.cdb_valid && !e.bv && e.bo == bus.cdb_tag) begin e.bv = 1; e.b = bus.cdb_value; end
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_rob_idx = 0; bus.in_opcode = 0; bus.in_imm = 0;
    bus.in_a_valid = 0; bus.in_a_value = 0; bus.in_a_owner = 0;
    bus.in_b_valid = 0; bus.in_b_value = 0; bus.in_b_owner = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0; bus.flush = 0;
  endtask

  task automatic push_in(input logic [3:0] rob, input bit av, input logic [15:0] a, input logic [3:0] ao,
                         input bit bv, input logic [15:0] b, input logic [3:0] bo);
    bus.in_valid = 1; bus.in_rob_idx = rob; bus.in_opcode = rob ^ 4'h5; bus.in_imm = {rob, ~rob};
    bus.in_a_valid = av; bus.in_a_value = a; bus.in_a_owner = ao;
    bus.in_b_valid = bv; bus.in_b_value = b; bus.in_b_owner = bo;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [15:0] val);
    bus.cdb_valid = 1; bus.cdb_tag = tag; bus.cdb_value = val;
  endtask

  initial begin
    idle();
    bus.issue_ready = 0;
    reset = 1;
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    check("reset_full", 64'(bus.full), 64'd0);
    check("reset_issue_valid", 64'(bus.issue_valid), 64'd0);

    // Fully valid dispatch issues one cycle later
    bus.issue_ready = 1;
    push_in(4'd3, 1, 16'd5, 4'd0, 1, 16'd7, 4'd0);
    tick(); idle();
    check("t1_valid", 64'(bus.issue_valid), 64'd1);
    check("t1_rob", 64'(bus.issue_rob_idx), 64'd3);
    check("t1_a", 64'(bus.issue_a_value), 64'd5);
    check("t1_b", 64'(bus.issue_b_value), 64'd7);
    tick();
    check("t1_empty", 64'(bus.issue_valid), 64'd0);

    // Older entry woken by CDB overtakes a younger ready one
    bus.issue_ready = 0;
    push_in(4'd1, 0, 16'd0, 4'd9, 1, 16'd2, 4'd0);
    tick();
    push_in(4'd2, 1, 16'd10, 4'd0, 1, 16'd11, 4'd0);
    tick(); idle();
    check("t2_young_rob", 64'(bus.issue_rob_idx), 64'd2);
    cdb(4'd9, 16'h1234);
    tick(); idle();
    bus.issue_ready = 1;
    check("t2_old_rob", 64'(bus.issue_rob_idx), 64'd1);
    check("t2_old_a", 64'(bus.issue_a_value), 64'h1234);
    tick();
    check("t2_second_rob", 64'(bus.issue_rob_idx), 64'd2);
    tick();
    check("t2_drained", 64'(bus.issue_valid), 64'd0);

    // Same-cycle capture on dispatch
    push_in(4'd4, 1, 16'd1, 4'd0, 0, 16'd0, 4'd6);
    cdb(4'd6, 16'hBEEF);
    tick(); idle();
    check("t3_rob", 64'(bus.issue_rob_idx), 64'd4);
    check("t3_b", 64'(bus.issue_b_value), 64'hBEEF);
    tick();

    // Fill, drop while full, wake middle slot
    bus.issue_ready = 0;
    for (int k = 0; k < 4; k++) begin
      push_in(4'(10 + k), 0, 16'd0, 4'(5 + k), 0, 16'd0, 4'(5 + k));
      tick();
    end
    idle();
    check("t4_full", 64'(bus.full), 64'd1);
    push_in(4'd8, 1, 16'd1, 4'd0, 1, 16'd1, 4'd0);
    tick(); idle();
    check("t4_still_full", 64'(bus.full), 64'd1);
    check("t4_none_ready", 64'(bus.issue_valid), 64'd0);
    cdb(4'd7, 16'h0077);
    tick(); idle();
    check("t4_slot2_rob", 64'(bus.issue_rob_idx), 64'd12);
    bus.issue_ready = 1;
    tick();
    bus.issue_ready = 0;
    check("t4_not_full", 64'(bus.full), 64'd0);

    // Flush with ready entries and a simultaneous dispatch
    cdb(4'd5, 16'h0055); tick();
    cdb(4'd6, 16'h0066); tick();
    cdb(4'd8, 16'h0088); tick(); idle();
    check("t5_oldest_rob", 64'(bus.issue_rob_idx), 64'd10);
    bus.flush = 1;
    push_in(4'd9, 1, 16'd3, 4'd0, 1, 16'd4, 4'd0);
    tick(); idle();
    check("t5_full", 64'(bus.full), 64'd0);
    check("t5_valid", 64'(bus.issue_valid), 64'd0);
    tick();
    check("t5_push_absent", 64'(bus.issue_valid), 64'd0);

    // Reset mid-operation, stale tag afterwards
    push_in(4'd1, 0, 16'd0, 4'd3, 1, 16'd1, 4'd0); tick();
    push_in(4'd2, 1, 16'd1, 4'd0, 0, 16'd0, 4'd3); tick(); idle();
    reset = 1;
    cdb(4'd3, 16'h3333);
    tick(); idle();
    reset = 0;
    check("t6_valid", 64'(bus.issue_valid), 64'd0);
    check("t6_payload", 64'(dut_payload()), 64'd0);
    check("t6_full", 64'(bus.full), 64'd0);
    cdb(4'd3, 16'h3333);
    tick(); idle();
    check("t6_stale_tag", 64'(bus.issue_valid), 64'd0);

    for (int n = 0; n < 800; n++) begin
      bus.in_valid    = ($urandom_range(0, 9) < 6);
      bus.in_rob_idx  = 4'($urandom);
      bus.in_opcode   = 4'($urandom);
      bus.in_imm      = 8'($urandom);
      bus.in_a_valid  = $urandom_range(0, 1);
      bus.in_a_value  = 16'($urandom);
      bus.in_a_owner  = 4'($urandom_range(0, 5));
      bus.in_b_valid  = $urandom_range(0, 1);
      bus.in_b_value  = 16'($urandom);
      bus.in_b_owner  = 4'($urandom_range(0, 5));
      bus.cdb_valid   = $urandom_range(0, 1);
      bus.cdb_tag     = 4'($urandom_range(0, 5));
      bus.cdb_value   = 16'($urandom);
      bus.flush       = ($urandom_range(0, 39) == 0);
      bus.issue_ready = ($urandom_range(0, 9) < 4);
      reset           = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 0;
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
